// File: rtl/ysyx_22040125_mem_arbiter_if.sv
// Request/response handshakes and RAM port of the IF/LSU memory arbiter.
// slave: the arbiter side; master: the requesters and the RAM.
interface ysyx_22040125_mem_arbiter_if #(
    parameter int unsigned RAM_AW = 32
) ();
    logic              if_req_valid;
    logic              if_req_ready;
    logic [63:0]       if_req_addr;
    logic              if_resp_valid;
    logic              if_resp_ready;
    logic [63:0]       if_resp_data;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [63:0]       lsu_req_addr;
    logic              lsu_req_wen;
    logic [63:0]       lsu_req_wdata;
    logic [7:0]        lsu_req_wstrb;
    logic              lsu_resp_valid;
    logic              lsu_resp_ready;
    logic [63:0]       lsu_resp_rdata;

    logic [RAM_AW-1:0] ram_addr;
    logic [63:0]       ram_wdata;
    logic              ram_wen;
    logic [63:0]       ram_rdata;

    modport slave (
        input  if_req_valid, if_req_addr, if_resp_ready,
        output if_req_ready, if_resp_valid, if_resp_data,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb,
        input  lsu_resp_ready,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
        output ram_addr, ram_wdata, ram_wen,
        input  ram_rdata
    );

    modport master (
        output if_req_valid, if_req_addr, if_resp_ready,
        input  if_req_ready, if_resp_valid, if_resp_data,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb,
        output lsu_resp_ready,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
        input  ram_addr, ram_wdata, ram_wen,
        output ram_rdata
    );
endinterface

// File: rtl/ysyx_22040125_mem_arbiter.sv
// Shares one single-port 64-bit RAM between IF reads and LSU reads/writes (read-merge-write).
// Define YSYX_22040125_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of LSU priority.
module ysyx_22040125_mem_arbiter #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned RAM_AW    = 32
) (
    input logic                        clk,
    input logic                        rst,
    ysyx_22040125_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StMergeWr, StResp} state_e;

    state_e            state_q, state_d;
    logic [RAM_AW-1:0] idx_q, idx_d;
    logic              wen_q, wen_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [7:0]        wstrb_q, wstrb_d;
    logic              owner_lsu_q, owner_lsu_d;
    logic [63:0]       merged_q, merged_d;
    logic [63:0]       rdata_q, rdata_d;

    logic              lsu_win, if_win;
    logic [63:0]       req_off;
    logic [63:0]       strb_mask;
    logic              ram_wen;
    logic [63:0]       ram_wdata;

`ifdef YSYX_22040125_ARB_ROUND_ROBIN_EN
    logic last_lsu_q, last_lsu_d;
    // On a tie the requester that was not granted last wins.
    assign lsu_win = bus.lsu_req_valid && (!bus.if_req_valid || !last_lsu_q);
`else
    assign lsu_win = bus.lsu_req_valid;
`endif
    assign if_win = bus.if_req_valid && !lsu_win;

    assign bus.lsu_req_ready  = (state_q == StIdle) && lsu_win;
    assign bus.if_req_ready   = (state_q == StIdle) && if_win;
    assign bus.lsu_resp_valid = (state_q == StResp) && owner_lsu_q;
    assign bus.if_resp_valid  = (state_q == StResp) && !owner_lsu_q;
    assign bus.lsu_resp_rdata = rdata_q;
    assign bus.if_resp_data   = rdata_q;
    assign bus.ram_addr       = idx_q;
    assign bus.ram_wen        = ram_wen;
    assign bus.ram_wdata      = ram_wdata;

    always_comb begin
        req_off = ((lsu_win ? bus.lsu_req_addr : bus.if_req_addr) - BASE_ADDR) >> 3;
        for (int i = 0; i < 8; i++) begin
            strb_mask[8*i +: 8] = {8{wstrb_q[i]}};
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        owner_lsu_d = owner_lsu_q;
        merged_d    = merged_q;
        rdata_d     = rdata_q;
        ram_wen     = 1'b0;
        ram_wdata   = 64'h0;
`ifdef YSYX_22040125_ARB_ROUND_ROBIN_EN
        last_lsu_d  = last_lsu_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (lsu_win || if_win) begin
                    idx_d       = req_off[RAM_AW-1:0];
                    wen_d       = lsu_win && bus.lsu_req_wen;
                    wdata_d     = bus.lsu_req_wdata;
                    wstrb_d     = bus.lsu_req_wstrb;
                    owner_lsu_d = lsu_win;
`ifdef YSYX_22040125_ARB_ROUND_ROBIN_EN
                    last_lsu_d  = lsu_win;
`endif
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                if (!wen_q) begin
                    rdata_d = bus.ram_rdata;
                    state_d = StResp;
                end else if (wstrb_q == 8'hFF) begin
                    ram_wen   = 1'b1;
                    ram_wdata = wdata_q;
                    rdata_d   = 64'h0;
                    state_d   = StResp;
                end else if (wstrb_q == 8'h00) begin
                    rdata_d = 64'h0;
                    state_d = StResp;
                end else begin
                    // RAM only takes whole words: splice the strobed bytes into the old word.
                    merged_d = (wdata_q & strb_mask) | (bus.ram_rdata & ~strb_mask);
                    rdata_d  = 64'h0;
                    state_d  = StMergeWr;
                end
            end
            StMergeWr: begin
                ram_wen   = 1'b1;
                ram_wdata = merged_q;
                state_d   = StResp;
            end
            StResp: begin
                if (owner_lsu_q ? bus.lsu_resp_ready : bus.if_resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= 64'h0;
            wstrb_q     <= 8'h0;
            owner_lsu_q <= 1'b0;
            merged_q    <= 64'h0;
            rdata_q     <= 64'h0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            owner_lsu_q <= owner_lsu_d;
            merged_q    <= merged_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef YSYX_22040125_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_lsu_q <= 1'b1;
        end else begin
            last_lsu_q <= last_lsu_d;
        end
    end
`endif
endmodule

// File: tb/tb_ysyx_22040125_mem_arbiter.sv
// Scoreboard bench for ysyx_22040125_mem_arbiter: directed cases then random IF/LSU traffic.
module tb_ysyx_22040125_mem_arbiter;
    localparam logic [63:0] Base  = 64'h8000_0000;
    localparam int unsigned RamAw = 32;
    localparam int          Words = 16;
`ifdef YSYX_22040125_ARB_ROUND_ROBIN_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    typedef struct {
        logic        lsu;
        logic [63:0] data;
        int          acc;
        int          lat;
        int          wen_n;
        int          wen_at;
        logic [31:0] ra;
        logic [63:0] wword;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_init = 1'b1;
    int   cycle = 0;
    int   tests = 0;
    int   fails = 0;

    ysyx_22040125_mem_arbiter_if #(.RAM_AW(RamAw)) bus ();

    ysyx_22040125_mem_arbiter #(
        .BASE_ADDR(Base),
        .RAM_AW   (RamAw)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [63:0] init_word(input int i);
        return 64'hC0DE_0000_0000_0000 | (64'(i) << 16) | (64'(i) << 4);
    endfunction

    // RAM: combinational read, write at posedge.
    logic [63:0] ram [Words];
    assign bus.ram_rdata = ram[bus.ram_addr[3:0]];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < Words; i++) ram[i] <= init_word(i);
        end else if (bus.ram_wen) begin
            ram[bus.ram_addr[3:0]] <= bus.ram_wdata;
        end
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, want %b (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model and scoreboard state.
    logic [63:0] ref_mem [Words];
    exp_t        exp_q[$];
    logic        acc_log[$];
    logic        busy, last_lsu_m, started;
    logic [63:0] held, last_if_data, last_lsu_data;
    int          seen_n, seen_at, last_if_acc, last_lsu_hs;
    exp_t        e;
    logic [63:0] a, off, w, od;
    logic        ov, orr, acc_l, acc_i, exp_lr, exp_ir;
    int          k;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            busy       = 1'b0;
            started    = 1'b0;
            seen_n     = 0;
            last_lsu_m = 1'b1;
            if (ram_init) for (int i = 0; i < Words; i++) ref_mem[i] = init_word(i);
            check_bit("rst_ram_wen", bus.ram_wen, 1'b0);
            check64("rst_ram_addr", 64'(bus.ram_addr), 64'h0);
            check64("rst_ram_wdata", bus.ram_wdata, 64'h0);
            check_bit("rst_if_resp_valid", bus.if_resp_valid, 1'b0);
            check_bit("rst_lsu_resp_valid", bus.lsu_resp_valid, 1'b0);
            check64("rst_lsu_rdata", bus.lsu_resp_rdata, 64'h0);
            check64("rst_if_data", bus.if_resp_data, 64'h0);
        end else begin
            exp_lr = 1'b0;
            exp_ir = 1'b0;
            if (!busy) begin
                if (bus.lsu_req_valid && bus.if_req_valid) begin
                    if (RrEn && last_lsu_m) exp_ir = 1'b1;
                    else exp_lr = 1'b1;
                end else begin
                    exp_lr = bus.lsu_req_valid;
                    exp_ir = bus.if_req_valid;
                end
            end
            check_bit("lsu_req_ready", bus.lsu_req_ready, exp_lr);
            check_bit("if_req_ready", bus.if_req_ready, exp_ir);

            if (exp_q.size() == 0) begin
                check_bit("ram_wen_idle", bus.ram_wen, 1'b0);
                check_bit("if_resp_valid_idle", bus.if_resp_valid, 1'b0);
                check_bit("lsu_resp_valid_idle", bus.lsu_resp_valid, 1'b0);
            end else if (bus.ram_wen) begin
                seen_n++;
                seen_at = cycle;
                check64("ram_addr", 64'(bus.ram_addr), 64'(exp_q[0].ra));
                check64("ram_wdata", bus.ram_wdata, exp_q[0].wword);
            end

            if (exp_q.size() != 0) begin
                e   = exp_q[0];
                ov  = e.lsu ? bus.lsu_resp_valid : bus.if_resp_valid;
                od  = e.lsu ? bus.lsu_resp_rdata : bus.if_resp_data;
                orr = e.lsu ? bus.lsu_resp_ready : bus.if_resp_ready;
                check_bit("other_resp_valid", e.lsu ? bus.if_resp_valid : bus.lsu_resp_valid, 1'b0);
                if (!started) begin
                    if (ov) begin
                        started = 1'b1;
                        held    = od;
                        check_int("resp_latency", cycle - e.acc, e.lat);
                        check64("resp_data", od, e.data);
                    end else if (cycle - e.acc > 50) begin
                        check_int("resp_timeout", cycle - e.acc, e.lat);
                        void'(exp_q.pop_front());
                        busy = 1'b0;
                        seen_n = 0;
                    end
                end else begin
                    check_bit("resp_valid_held", ov, 1'b1);
                    check64("resp_data_held", od, held);
                end
                if (started && ov && orr) begin
                    check_int("ram_wen_count", seen_n, e.wen_n);
                    if (e.wen_n != 0) check_int("ram_wen_cycle", seen_at, e.wen_at);
                    if (e.lsu) begin
                        last_lsu_data = od;
                        last_lsu_hs   = cycle;
                    end else begin
                        last_if_data = od;
                    end
                    void'(exp_q.pop_front());
                    busy    = 1'b0;
                    started = 1'b0;
                    seen_n  = 0;
                end
            end

            acc_l = bus.lsu_req_valid && bus.lsu_req_ready;
            acc_i = bus.if_req_valid && bus.if_req_ready && !acc_l;
            if (acc_l || acc_i) begin
                a       = acc_l ? bus.lsu_req_addr : bus.if_req_addr;
                off     = (a - Base) >> 3;
                k       = int'(off[3:0]);
                e.lsu   = acc_l;
                e.acc   = cycle;
                e.ra    = off[31:0];
                e.wen_n = 0;
                e.wen_at = -1;
                e.wword = 64'h0;
                e.lat   = 2;
                if (acc_l && bus.lsu_req_wen) begin
                    e.data = 64'h0;
                    w = ref_mem[k];
                    for (int b = 0; b < 8; b++) begin
                        if (bus.lsu_req_wstrb[b]) w[8*b +: 8] = bus.lsu_req_wdata[8*b +: 8];
                    end
                    if (bus.lsu_req_wstrb == 8'hFF) begin
                        e.wen_n = 1;
                        e.wen_at = cycle + 1;
                        e.wword = w;
                    end else if (bus.lsu_req_wstrb != 8'h00) begin
                        e.lat = 3;
                        e.wen_n = 1;
                        e.wen_at = cycle + 2;
                        e.wword = w;
                    end
                    ref_mem[k] = w;
                end else begin
                    e.data = ref_mem[k];
                end
                exp_q.push_back(e);
                acc_log.push_back(acc_l);
                busy       = 1'b1;
                last_lsu_m = acc_l;
                if (acc_i) last_if_acc = cycle;
            end
        end
    end

    task automatic issue_lsu(input logic [63:0] ad, input logic we, input logic [63:0] d,
                             input logic [7:0] s);
        int n = 0;
        @(posedge clk);
        #1;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_req_addr  = ad;
        bus.lsu_req_wen   = we;
        bus.lsu_req_wdata = d;
        bus.lsu_req_wstrb = s;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.lsu_req_ready && n < 300);
        if (n >= 300) check_int("lsu_accept_timeout", n, 0);
        @(posedge clk);
        #1;
        bus.lsu_req_valid = 1'b0;
    endtask

    task automatic issue_if(input logic [63:0] ad);
        int n = 0;
        @(posedge clk);
        #1;
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = ad;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.if_req_ready && n < 300);
        if (n >= 300) check_int("if_accept_timeout", n, 0);
        @(posedge clk);
        #1;
        bus.if_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((exp_q.size() != 0 || bus.if_req_valid || bus.lsu_req_valid) && n < 300);
        if (n >= 300) check_int("idle_timeout", n, 0);
    endtask

    function automatic logic [63:0] rand_addr();
        return Base + 64'(8 * $urandom_range(0, Words - 1)) + 64'($urandom_range(0, 7));
    endfunction

    logic [63:0] saved;
    logic        drv_done;

    initial begin
        bus.if_req_valid   = 1'b0;
        bus.if_req_addr    = 64'h0;
        bus.if_resp_ready  = 1'b1;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_req_addr   = 64'h0;
        bus.lsu_req_wen    = 1'b0;
        bus.lsu_req_wdata  = 64'h0;
        bus.lsu_req_wstrb  = 8'h0;
        bus.lsu_resp_ready = 1'b1;
        drv_done = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ram_init = 1'b0;

        // Full write then IF read of the same word.
        issue_lsu(Base + 64'h10, 1'b1, 64'h1122_3344_5566_7788, 8'hFF);
        issue_if(Base + 64'h10);
        wait_idle();
        check64("t1_if_data", last_if_data, 64'h1122_3344_5566_7788);
        check64("t1_ram_word", ram[2], 64'h1122_3344_5566_7788);

        // Partial write merges into an all-ones word.
        issue_lsu(Base + 64'h28, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        issue_lsu(Base + 64'h28, 1'b1, 64'h0000_0000_0000_00AB, 8'h01);
        wait_idle();
        check64("t2_merged_word", ram[5], 64'hFFFF_FFFF_FFFF_FFAB);

        // Empty-strobe write leaves RAM untouched and returns 0.
        issue_lsu(Base + 64'h30, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00);
        wait_idle();
        check64("t3_rdata", last_lsu_data, 64'h0);
        check64("t3_ram_word", ram[6], init_word(6));

        // Two ties in a row.
        acc_log.delete();
        fork
            issue_lsu(Base + 64'h08, 1'b0, 64'h0, 8'h0);
            issue_if(Base + 64'h18);
        join
        wait_idle();
        fork
            issue_lsu(Base + 64'h20, 1'b0, 64'h0, 8'h0);
            issue_if(Base + 64'h38);
        join
        wait_idle();
        check_int("tie_accepts", acc_log.size(), 4);
        if (acc_log.size() == 4) begin
            check_bit("tie1_first_is_lsu", acc_log[0], !RrEn);
            check_bit("tie1_second_is_lsu", acc_log[1], RrEn);
            check_bit("tie2_first_is_lsu", acc_log[2], !RrEn);
        end

        // Response backpressure with IF waiting.
        bus.lsu_resp_ready = 1'b0;
        issue_lsu(Base + 64'h10, 1'b0, 64'h0, 8'h0);
        fork
            issue_if(Base + 64'h28);
        join_none
        repeat (7) @(posedge clk);
        #1;
        check_bit("bp_lsu_valid_held", bus.lsu_resp_valid, 1'b1);
        bus.lsu_resp_ready = 1'b1;
        wait_idle();
        check_int("bp_if_accept_delay", last_if_acc - last_lsu_hs, 1);
        check64("bp_lsu_data", last_lsu_data, 64'h1122_3344_5566_7788);

        // Reset in the merge-write cycle drops the write.
        saved = ram[7];
        fork
            issue_lsu(Base + 64'h38, 1'b1, 64'h0000_0000_0000_5500, 8'h02);
        join_none
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.ram_wen && n < 50);
            if (n >= 50) check_int("merge_wen_timeout", n, 0);
        end
        #2;
        rst = 1'b1;
        #1;
        check_bit("rst_merge_wen_drop", bus.ram_wen, 1'b0);
        check_bit("rst_merge_lsu_valid", bus.lsu_resp_valid, 1'b0);
        check_bit("rst_merge_if_valid", bus.if_resp_valid, 1'b0);
        @(negedge clk);
        #1;
        ref_mem[7] = saved;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check64("rst_merge_ram_word", ram[7], saved);
        bus.lsu_req_valid = 1'b0;
        issue_lsu(Base + 64'h38, 1'b0, 64'h0, 8'h0);
        wait_idle();
        check64("rst_merge_readback", last_lsu_data, saved);

        // Random concurrent traffic with random response stalls.
        fork
            begin
                fork
                    for (int i = 0; i < 40; i++) begin
                        logic [7:0] s;
                        int r = $urandom_range(0, 3);
                        s = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
                        issue_lsu(rand_addr(), 1'($urandom), {$urandom, $urandom}, s);
                        repeat ($urandom_range(0, 2)) @(posedge clk);
                    end
                    for (int i = 0; i < 40; i++) begin
                        issue_if(rand_addr());
                        repeat ($urandom_range(0, 2)) @(posedge clk);
                    end
                join
                drv_done = 1'b1;
            end
            while (!drv_done) begin
                @(posedge clk);
                #1;
                bus.if_resp_ready  = ($urandom_range(0, 3) != 0);
                bus.lsu_resp_ready = ($urandom_range(0, 3) != 0);
            end
        join
        bus.if_resp_ready  = 1'b1;
        bus.lsu_resp_ready = 1'b1;
        wait_idle();
        for (int i = 0; i < Words; i++) check64("final_ram_word", ram[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
